// File: rtl/conv_mac_if.sv
// Operand/result bundle between the coprocessor decoder (master) and the
// sequential convolution engine (slave).
interface conv_mac_if #(
  parameter int DATA_W  = 8,
  parameter int MAX_DIM = 5,
  parameter int ACC_W   = 22
);
  localparam int DIM_W = $clog2(MAX_DIM + 1);
  localparam int VEC_W = MAX_DIM * MAX_DIM * DATA_W;

  // Handshake: start is a request sampled on a rising edge only while the
  // engine is idle (busy=0); busy covers RUN and DONE, and done is a
  // one-cycle pulse marking the first cycle in which results are valid.
  logic                     start;
  logic [VEC_W-1:0]         pixel;
  logic [VEC_W-1:0]         kernel;
  logic [DIM_W-1:0]         dim;
  logic                     abs_mode;
  logic                     busy;
  logic                     done;
  logic signed [ACC_W-1:0]  acc_out;
  logic [DATA_W-1:0]        sat_out;
  logic                     sat_flag;

  modport master (
    output start, pixel, kernel, dim, abs_mode,
    input  busy, done, acc_out, sat_out, sat_flag
  );

  modport slave (
    input  start, pixel, kernel, dim, abs_mode,
    output busy, done, acc_out, sat_out, sat_flag
  );
endinterface

// File: rtl/conv_mac_engine.sv
// One convolution window of up to MAX_DIM x MAX_DIM, one signed MAC per
// cycle, with full-precision result and clamp / abs-clamp saturation.
module conv_mac_engine #(
  parameter int DATA_W  = 8,
  parameter int MAX_DIM = 5,
  parameter int ACC_W   = 22
) (
  input  logic       clk,
  input  logic       rst_n,
  conv_mac_if.slave  bus,
  output logic [1:0] o_dbg_state
);
  localparam int DIM_W  = $clog2(MAX_DIM + 1);
  localparam int NEL    = MAX_DIM * MAX_DIM;
  localparam int IDX_W  = (NEL > 1) ? $clog2(NEL) : 1;
  localparam int VEC_W  = NEL * DATA_W;
  localparam int PROD_W = 2 * DATA_W + 1;

  localparam logic [DIM_W-1:0]        DIM_LO  = DIM_W'(2);
  localparam logic [DIM_W-1:0]        DIM_HI  = DIM_W'(MAX_DIM);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << DATA_W) - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t                   r_state;
  state_t                   w_next;
  logic [VEC_W-1:0]         r_pixel;
  logic [VEC_W-1:0]         r_kernel;
  logic [DIM_W-1:0]         r_dim;
  logic                     r_abs;
  logic [DIM_W-1:0]         r_row;
  logic [DIM_W-1:0]         r_col;
  logic signed [ACC_W-1:0]  r_acc;
  logic signed [ACC_W-1:0]  r_acc_out;
  logic [DATA_W-1:0]        r_sat_out;
  logic                     r_sat_flag;

  logic [DIM_W-1:0]         w_dim_clamped;
  logic [IDX_W-1:0]         w_idx;
  logic [DATA_W-1:0]        w_pix;
  logic [DATA_W-1:0]        w_coef;
  logic signed [PROD_W-1:0] w_pix_s;
  logic signed [PROD_W-1:0] w_coef_s;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_acc_next;
  logic signed [ACC_W-1:0]  w_mag;
  logic [DATA_W-1:0]        w_sat;
  logic                     w_sat_flag;
  logic                     w_col_end;
  logic                     w_row_end;
  logic                     w_last;

  always_comb begin
    w_dim_clamped = bus.dim;
    if (bus.dim < DIM_LO) begin
      w_dim_clamped = DIM_LO;
    end else if (bus.dim > DIM_HI) begin
      w_dim_clamped = DIM_HI;
    end
  end

  // Pixels are unsigned: a zero MSB is prepended before the signed multiply.
  assign w_idx      = IDX_W'(r_row) * IDX_W'(MAX_DIM) + IDX_W'(r_col);
  assign w_pix      = r_pixel[w_idx * DATA_W +: DATA_W];
  assign w_coef     = r_kernel[w_idx * DATA_W +: DATA_W];
  assign w_pix_s    = PROD_W'($signed({1'b0, w_pix}));
  assign w_coef_s   = PROD_W'($signed(w_coef));
  assign w_prod     = w_pix_s * w_coef_s;
  assign w_acc_next = r_acc + ACC_W'(w_prod);

  assign w_col_end  = (r_col == r_dim - DIM_W'(1));
  assign w_row_end  = (r_row == r_dim - DIM_W'(1));
  assign w_last     = w_col_end && w_row_end;

  // Saturation acts on the sum that includes the final product, so the
  // registered results are ready in the same edge that enters DONE.
  always_comb begin
    w_mag      = w_acc_next;
    w_sat      = w_acc_next[DATA_W-1:0];
    w_sat_flag = 1'b0;
    if (r_abs && (w_acc_next < 0)) begin
      w_mag = -w_acc_next;
      w_sat = w_mag[DATA_W-1:0];
    end
    if (w_mag < 0) begin
      w_sat      = '0;
      w_sat_flag = 1'b1;
    end else if (w_mag > SAT_MAX) begin
      w_sat      = '1;
      w_sat_flag = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    bus.busy = (r_state != S_IDLE);
    bus.done = (r_state == S_DONE);
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pixel    <= '0;
      r_kernel   <= '0;
      r_dim      <= '0;
      r_abs      <= 1'b0;
      r_row      <= '0;
      r_col      <= '0;
      r_acc      <= '0;
      r_acc_out  <= '0;
      r_sat_out  <= '0;
      r_sat_flag <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_pixel  <= bus.pixel;
            r_kernel <= bus.kernel;
            r_dim    <= w_dim_clamped;
            r_abs    <= bus.abs_mode;
            r_row    <= '0;
            r_col    <= '0;
            r_acc    <= '0;
          end
        end
        S_RUN: begin
          r_acc <= w_acc_next;
          if (w_col_end) begin
            r_col <= '0;
            r_row <= w_row_end ? '0 : r_row + DIM_W'(1);
          end else begin
            r_col <= r_col + DIM_W'(1);
          end
          if (w_last) begin
            r_acc_out  <= w_acc_next;
            r_sat_out  <= w_sat;
            r_sat_flag <= w_sat_flag;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.acc_out  = r_acc_out;
  assign bus.sat_out  = r_sat_out;
  assign bus.sat_flag = r_sat_flag;
  assign o_dbg_state  = r_state;
endmodule

// File: tb/tb_conv_mac_engine.sv
// Directed bench for conv_mac_engine: driver tasks push expected results,
// a negedge monitor pops and compares them whenever done pulses.
module tb_conv_mac_engine;
  localparam int DATA_W  = 8;
  localparam int MAX_DIM = 5;
  localparam int ACC_W   = 22;
  localparam int VEC_W   = MAX_DIM * MAX_DIM * DATA_W;
  localparam int EXP_W   = ACC_W + DATA_W + 1;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;
  int         n_cmp;
  int         n_fail;

  logic [EXP_W-1:0] exp_q[$];

  conv_mac_if #(.DATA_W(DATA_W), .MAX_DIM(MAX_DIM), .ACC_W(ACC_W)) bus ();

  conv_mac_engine #(.DATA_W(DATA_W), .MAX_DIM(MAX_DIM), .ACC_W(ACC_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [VEC_W-1:0] fill(input logic [7:0] v_in, input int n, input logic [7:0] v_out);
    logic [VEC_W-1:0] f;
    f = '0;
    for (int r = 0; r < MAX_DIM; r++)
      for (int c = 0; c < MAX_DIM; c++)
        f[(r*MAX_DIM+c)*DATA_W +: DATA_W] = (r < n && c < n) ? v_in : v_out;
    return f;
  endfunction

  // driver tasks
  task automatic start_op(input int d, input logic [VEC_W-1:0] px, input logic [VEC_W-1:0] kn, input logic ab);
    @(negedge clk);
    bus.dim      = 3'(d);
    bus.pixel    = px;
    bus.kernel   = kn;
    bus.abs_mode = ab;
    bus.start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start    = 1'b0;
    chk("busy_run", int'(bus.busy), 1);
  endtask

  task automatic push_exp(input int e_acc, input int e_sat, input int e_flag);
    logic [ACC_W-1:0]  a;
    logic [DATA_W-1:0] s;
    a = ACC_W'(e_acc);
    s = DATA_W'(e_sat);
    exp_q.push_back({a, s, e_flag[0]});
  endtask

  // lat counts edges starting with the one that sampled start
  task automatic wait_done(input int e_lat, input int lat0);
    int lat;
    lat = lat0;
    while (!bus.done && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk("latency", lat, e_lat);
    @(negedge clk);
    chk("busy_after_done", int'(bus.busy), 0);
  endtask

  task automatic do_run(input int d, input logic [VEC_W-1:0] px, input logic [VEC_W-1:0] kn, input logic ab,
                        input int e_acc, input int e_sat, input int e_flag, input int e_lat);
    push_exp(e_acc, e_sat, e_flag);
    start_op(d, px, kn, ab);
    wait_done(e_lat, 1);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (bus.done) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no pending result");
      end else begin
        logic [EXP_W-1:0] e;
        e = exp_q.pop_front();
        chk("acc_out", int'($signed(bus.acc_out)), int'($signed(e[EXP_W-1 -: ACC_W])));
        chk("sat_out", int'(bus.sat_out), int'(e[DATA_W:1]));
        chk("sat_flag", int'(bus.sat_flag), int'(e[0]));
      end
    end
  end

  initial begin
    logic [VEC_W-1:0] px;
    logic [VEC_W-1:0] kn;
    n_cmp        = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.pixel    = '0;
    bus.kernel   = '0;
    bus.dim      = '0;
    bus.abs_mode = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_acc", int'($signed(bus.acc_out)), 0);
    chk("rst_sat", int'(bus.sat_out), 0);
    chk("rst_flag", int'(bus.sat_flag), 0);
    rst_n = 1'b1;

    do_run(3, fill(8'd10, 5, 8'd10), fill(8'd1, 5, 8'd1), 1'b0, 90, 90, 0, 10);
    do_run(2, fill(8'd50, 5, 8'd50), fill(8'hFF, 5, 8'hFF), 1'b0, -200, 0, 1, 5);
    do_run(2, fill(8'd50, 5, 8'd50), fill(8'hFF, 5, 8'hFF), 1'b1, -200, 200, 0, 5);
    do_run(5, fill(8'd255, 5, 8'd255), fill(8'd127, 5, 8'd127), 1'b0, 809625, 255, 1, 26);
    do_run(3, fill(8'd255, 3, 8'd200), fill(8'd127, 3, 8'd77), 1'b0, 291465, 255, 1, 10);
    do_run(7, fill(8'd255, 5, 8'd255), fill(8'd127, 5, 8'd127), 1'b0, 809625, 255, 1, 26);
    do_run(0, fill(8'd3, 5, 8'd3), fill(8'd2, 5, 8'd2), 1'b0, 24, 24, 0, 5);
    do_run(2, fill(8'd100, 5, 8'd100), fill(8'd3, 5, 8'd3), 1'b1, 1200, 255, 1, 5);

    // operands changed and start re-pulsed mid-run: captured values win
    push_exp(90, 90, 0);
    start_op(3, fill(8'd10, 5, 8'd10), fill(8'd1, 5, 8'd1), 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus.pixel = fill(8'd99, 5, 8'd99);
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(10, 5);
    repeat (15) @(negedge clk);
    chk("no_second_run", int'(bus.busy), 0);

    // reset in the middle of a 5x5 run
    start_op(5, fill(8'd255, 5, 8'd255), fill(8'd127, 5, 8'd127), 1'b0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_done", int'(bus.done), 0);
    chk("midrst_acc", int'($signed(bus.acc_out)), 0);
    chk("midrst_sat", int'(bus.sat_out), 0);
    chk("midrst_flag", int'(bus.sat_flag), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // element layout check: (0,0)=1*1 (0,1)=2*-1 (1,0)=3*2 (1,1)=4*-2 = -3
    px = fill(8'd9, 0, 8'd9);
    kn = fill(8'd9, 0, 8'd9);
    px[0*DATA_W +: DATA_W] = 8'd1;
    px[1*DATA_W +: DATA_W] = 8'd2;
    px[5*DATA_W +: DATA_W] = 8'd3;
    px[6*DATA_W +: DATA_W] = 8'd4;
    kn[0*DATA_W +: DATA_W] = 8'd1;
    kn[1*DATA_W +: DATA_W] = 8'hFF;
    kn[5*DATA_W +: DATA_W] = 8'd2;
    kn[6*DATA_W +: DATA_W] = 8'hFE;
    do_run(2, px, kn, 1'b1, -3, 3, 0, 5);
    do_run(2, px, kn, 1'b0, -3, 0, 1, 5);

    repeat (5) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/conv_mac_engine.md
# conv_mac_engine

Sequential, parametrised convolution engine for the coprocessor datapath: it computes one window of a square kernel against a pixel window using a single multiply-accumulate per cycle. It generalises the single-cycle convolution unit to configurable data width, maximum kernel dimension and accumulator width. It adds a start/done handshake, a full-precision signed result and selectable output saturation (clamp or absolute-value clamp). It sits between the coprocessor instruction decoder, which supplies the operands and `start`, and the result writeback.

## Interface
- `DATA_W`, 8, element width; pixels unsigned, kernel coefficients two's-complement signed.
- `MAX_DIM`, 5, largest supported kernel dimension (window is MAX_DIM x MAX_DIM).
- `ACC_W`, 22, signed accumulator width; must be >= 2*DATA_W+1+clog2(MAX_DIM*MAX_DIM).
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; accepted only in IDLE.
- `pixel`  in  MAX_DIM*MAX_DIM*DATA_W  packed pixels; element (r,c) at bits [(r*MAX_DIM+c)*DATA_W +: DATA_W].
- `kernel`  in  MAX_DIM*MAX_DIM*DATA_W  packed coefficients, same layout.
- `dim`  in  clog2(MAX_DIM+1)  active kernel dimension; values <2 are treated as 2, values >MAX_DIM are treated as MAX_DIM.
- `abs_mode`  in  1  0 = clamp to [0, 2^DATA_W-1]; 1 = clamp |acc| to the same range.
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  one-cycle pulse; results valid from this cycle.
- `acc_out`  out  ACC_W  signed raw sum of products.
- `sat_out`  out  DATA_W  saturated result.
- `sat_flag`  out  1  set when clamping changed the value.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: when `start`=1, latch `pixel`, `kernel`, the clamped `dim` and `abs_mode` into internal registers. Clear the accumulator, set row=col=0, and go to RUN. Inputs are ignored after capture.
- RUN: each cycle, acc += signed({1'b0,pix[r][c]}) * kernel[r][c]. The product is 2*DATA_W+1 bits, sign-extended to ACC_W. Then advance col; at col=dim-1, wrap col to 0 and increment row. After the (dim-1, dim-1) MAC, go to DONE. Elements outside dim x dim are never read.
- DONE: register `acc_out`, `sat_out` and `sat_flag`, assert `done` for this one cycle, then return to IDLE.
- Saturation, with M = 2^DATA_W-1:
  - abs_mode=0: acc<0 gives 0; acc>M gives M; otherwise acc[DATA_W-1:0].
  - abs_mode=1: the same rule applied to |acc|.
  - `sat_flag` = the output differs from the unclamped value.
- `start` in RUN or DONE is ignored; it is not queued.
- `acc_out`, `sat_out` and `sat_flag` hold their values until the next DONE.
- No overflow of the accumulator is possible, given the ACC_W constraint.

## Timing
- Reset (asynchronous, any state): state=IDLE, `busy`=0, `done`=0, `acc_out`=0, `sat_out`=0, `sat_flag`=0, internal counters=0. A run in progress is abandoned with no `done`.
- `start` sampled high in IDLE at edge T: RUN covers cycles T+1..T+N, where N=dim*dim; `done`=1 and results valid during cycle T+N+1.
- Latency from start to done: N+1 cycles (5 for 2x2, 10 for 3x3, 17 for 4x4, 26 for 5x5).
- `busy` rises the cycle after the start edge and falls with the end of DONE.
- Earliest next `start` is accepted at the edge ending DONE + 1, i.e. in the IDLE cycle after the `done` pulse. Back-to-back throughput is N+2 cycles per result.

## Test plan
- dim=3, all pixels 10, all kernel 1, abs_mode=0 -> `done` at start+10, acc_out=90, sat_out=90, sat_flag=0.
- dim=2, pixels 50, kernel -1 (8'hFF), abs_mode=0 -> acc_out=-200, sat_out=0, sat_flag=1. Repeat with abs_mode=1 -> sat_out=200, sat_flag=0.
- dim=5, pixels 255, kernel 127 -> acc_out=809625, sat_out=255, sat_flag=1, `done` at start+26. Elements of a 5x5 window loaded with junk beyond dim=3 do not change a dim=3 result (9*255*127=291465).
- Operand change and re-start during RUN: change `pixel` and pulse `start` at cycle 4 of a dim=3 run -> result uses the captured operands, a single `done` pulse, no second run.
- `rst_n` low at cycle 6 of a dim=5 run -> all outputs 0 immediately, no `done`. A new run after release gives the correct result.
- dim=7 and dim=0 requests -> behave as dim=5 (26-cycle latency) and dim=2 (5-cycle latency) respectively.
